// File: rtl/sentinel_key_presenter.sv
// Initiator for the Sentinel perimeter gate: presents the key, waits for the gate's
// VERIFIED display, retries with key withdrawal, and latches hard faults.
module sentinel_key_presenter #(
    parameter logic [7:0] KEY            = 8'hB6,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter int         BACKOFF_CYCLES = 8,
    parameter int         MAX_RETRIES    = 3,
    parameter logic [7:0] SEG_LOCKED     = 8'hC7,
    parameter logic [7:0] SEG_VERIFIED   = 8'hC1,
    parameter logic [7:0] SEG_HARDLOCK   = 8'hC9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       release_req,
    input  logic [7:0] seg_in,
    input  logic [7:0] glow_in,
    output logic [7:0] key_out,
    output logic       busy,
    output logic       granted,
    output logic       fault,
    output logic       lost,
    output logic [2:0] retry_cnt
);

    localparam int TMAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BACKOFF_LAST = TW'(BACKOFF_CYCLES - 1);
    localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRIES);
    // A gate whose LOCKED and VERIFIED codes coincide can never be trusted to grant.
    localparam bit CODES_DISTINCT = (SEG_VERIFIED != SEG_LOCKED);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESENT = 3'd1,
        S_BACKOFF = 3'd2,
        S_GRANTED = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] timer, next_timer;
    logic [2:0]    next_retry;
    logic          next_lost;
    logic [7:0]    next_key;
    logic          next_busy, next_granted, next_fault;

    logic verified, hardlock;
    assign verified = CODES_DISTINCT && (seg_in == SEG_VERIFIED) && (glow_in == 8'hFF);
    assign hardlock = (seg_in == SEG_HARDLOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            retry_cnt <= 3'd0;
            key_out   <= 8'h00;
            busy      <= 1'b0;
            granted   <= 1'b0;
            fault     <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state     <= next_state;
            timer     <= next_timer;
            retry_cnt <= next_retry;
            key_out   <= next_key;
            busy      <= next_busy;
            granted   <= next_granted;
            fault     <= next_fault;
            lost      <= next_lost;
        end
    end

    always_comb begin
        next_state = state;
        next_timer = timer + 1'b1;
        next_retry = retry_cnt;
        next_lost  = 1'b0;
        case (state)
            S_IDLE: begin
                next_timer = '0;
                if (start) begin
                    next_state = S_PRESENT;
                    next_retry = 3'd0;
                end
            end
            S_PRESENT: begin
                if (hardlock)                 next_state = S_FAULT;
                else if (release_req)         next_state = S_IDLE;
                else if (verified)            next_state = S_GRANTED;
                else if (timer == TIMEOUT_LAST) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        next_state = S_BACKOFF;
                        next_timer = '0;
                    end else begin
                        next_state = S_FAULT;
                    end
                end
            end
            S_BACKOFF: begin
                if (hardlock)                 next_state = S_FAULT;
                else if (release_req)         next_state = S_IDLE;
                else if (timer == BACKOFF_LAST) begin
                    next_state = S_PRESENT;
                    next_timer = '0;
                    if (retry_cnt < RETRY_LIMIT) next_retry = retry_cnt + 3'd1;
                end
            end
            S_GRANTED: begin
                next_timer = '0;
                if (hardlock)                 next_state = S_FAULT;
                else if (release_req)         next_state = S_IDLE;
                else if (!verified) begin
                    next_state = S_IDLE;
                    next_lost  = 1'b1;
                end
            end
            S_FAULT: begin
                next_timer = '0;
            end
            default: begin
                next_state = S_FAULT;
                next_timer = '0;
            end
        endcase
    end

    // Outputs are decoded from the state being entered so they register alongside it.
    always_comb begin
        next_key     = 8'h00;
        next_busy    = 1'b0;
        next_granted = 1'b0;
        next_fault   = 1'b0;
        case (next_state)
            S_IDLE: ;
            S_PRESENT: begin
                next_key  = KEY;
                next_busy = 1'b1;
            end
            S_BACKOFF: next_busy = 1'b1;
            S_GRANTED: begin
                next_key     = KEY;
                next_granted = 1'b1;
            end
            default: next_fault = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sentinel_key_presenter.sv
// Self-checking bench for sentinel_key_presenter: a behavioural gate model answers the key,
// and expected outputs come from a timeline model of attempts, backoffs and injected events.
module tb_sentinel_key_presenter;

    localparam logic [7:0] KEY      = 8'hB6;
    localparam logic [7:0] SEG_VER  = 8'hC1;
    localparam logic [7:0] SEG_LCK  = 8'hC7;
    localparam logic [7:0] SEG_HL   = 8'hC9;
    localparam int TIMEOUT  = 16;
    localparam int BACKOFF  = 8;
    localparam int PERIOD   = TIMEOUT + BACKOFF;
    localparam int FAULT_AT = 4 * TIMEOUT + 3 * BACKOFF;

    typedef struct packed {
        logic [7:0] key;
        logic       busy;
        logic       granted;
        logic       fault;
        logic       lost;
        logic [2:0] retry;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       release_req = 1'b0;
    logic [7:0] seg_in, glow_in;
    logic [7:0] key_out;
    logic       busy, granted, fault, lost;
    logic [2:0] retry_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Gate model state and scenario knobs.
    logic       gate_ok;
    logic [7:0] gate_prev;
    int         gate_pres;
    int         accept_after = 0;
    logic       partial = 1'b0;
    logic       hl_drv = 1'b0;
    logic       drop_drv = 1'b0;

    sentinel_key_presenter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .release_req(release_req),
        .seg_in     (seg_in),
        .glow_in    (glow_in),
        .key_out    (key_out),
        .busy       (busy),
        .granted    (granted),
        .fault      (fault),
        .lost       (lost),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    // The gate counts fresh key presentations and verifies from presentation accept_after+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_ok   <= 1'b0;
            gate_prev <= 8'h00;
            gate_pres <= 0;
        end else begin
            gate_pres <= gate_pres + ((key_out == KEY && gate_prev != KEY) ? 1 : 0);
            gate_prev <= key_out;
            gate_ok   <= (key_out == KEY) &&
                         ((gate_pres + ((gate_prev != KEY) ? 1 : 0)) > accept_after);
        end
    end

    always_comb begin
        seg_in  = SEG_LCK;
        glow_in = 8'h00;
        if (hl_drv) begin
            seg_in = SEG_HL;
        end else if (partial) begin
            seg_in  = SEG_VER;
            glow_in = 8'h7F;
        end else if (gate_ok) begin
            seg_in  = SEG_VER;
            glow_in = drop_drv ? 8'h00 : 8'hFF;
        end
    end

    // Undisturbed timeline k edges after the start edge; acc = attempts the gate rejects (4 = all).
    function automatic vec_t base_at(int k, int acc);
        vec_t v;
        int a, r;
        v = '0;
        if (acc < 4 && k >= acc * PERIOD + 2) begin
            v.key = KEY; v.granted = 1'b1; v.retry = 3'(acc);
        end else if (k >= FAULT_AT) begin
            v.fault = 1'b1; v.retry = 3'd3;
        end else begin
            a = k / PERIOD;
            r = k % PERIOD;
            v.busy  = 1'b1;
            v.retry = 3'(a);
            v.key   = (r < TIMEOUT) ? KEY : 8'h00;
        end
        return v;
    endfunction

    // Applies the first effective injected event (hardlock > release > glow drop) to the timeline.
    function automatic vec_t exp_at(int k, int acc, int hl_e, int rel_e, int drop_e);
        vec_t prev, v;
        for (int e = 1; e <= k; e++) begin
            prev = base_at(e - 1, acc);
            if (prev.busy || prev.granted) begin
                v = '0;
                v.retry = prev.retry;
                if (e == hl_e) begin
                    v.fault = 1'b1;
                    return v;
                end
                if (e == rel_e) return v;
                if (e == drop_e && prev.granted) begin
                    v.lost = (k == e);
                    return v;
                end
            end
        end
        return base_at(k, acc);
    endfunction

    function automatic vec_t observe();
        vec_t v;
        v = {key_out, busy, granted, fault, lost, retry_cnt};
        return v;
    endfunction

    function automatic string fmt(vec_t v);
        return $sformatf("key=%h busy=%b granted=%b fault=%b lost=%b retry=%0d",
                         v.key, v.busy, v.granted, v.fault, v.lost, v.retry);
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        release_req = 1'b0;
        hl_drv      = 1'b0;
        drop_drv    = 1'b0;
        partial     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic launch(int acc, logic part, logic rel_too);
        do_reset();
        accept_after = (acc >= 4) ? 99 : acc;
        partial      = part;
        start        = 1'b1;
        release_req  = rel_too;
        @(posedge clk);
        #1;
        start       = 1'b0;
        release_req = 1'b0;
    endtask

    task automatic advance(int e, int hl_e, int rel_e, int drop_e);
        @(negedge clk);
        hl_drv      = (e == hl_e);
        release_req = (e == rel_e);
        drop_drv    = (e == drop_e);
        @(posedge clk);
        #1;
        hl_drv      = 1'b0;
        release_req = 1'b0;
        drop_drv    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (observe() !== vec_t'('0)) begin
            miscompares++;
            $display("[TB] FAIL reset got %s, expected all zero", fmt(observe()));
        end
    endtask

    task automatic test_nominal();
        vec_t e;
        launch(0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            e = exp_at(k, 0, -1, -1, -1);
            vectors++;
            if (observe() !== e) begin
                miscompares++;
                $display("[TB] FAIL nominal k=%0d got %s, expected %s", k, fmt(observe()), fmt(e));
            end
            advance(k + 1, -1, -1, -1);
        end
    endtask

    task automatic test_retry();
        vec_t e;
        launch(1, 1'b0, 1'b0);
        for (int k = 0; k < 34; k++) begin
            e = exp_at(k, 1, -1, -1, -1);
            vectors++;
            if (observe() !== e) begin
                miscompares++;
                $display("[TB] FAIL retry k=%0d got %s, expected %s", k, fmt(observe()), fmt(e));
            end
            advance(k + 1, -1, -1, -1);
        end
    endtask

    task automatic test_exhaustion();
        vec_t e;
        launch(4, 1'b0, 1'b0);
        for (int k = 0; k < FAULT_AT + 4; k++) begin
            e = exp_at(k, 4, -1, -1, -1);
            vectors++;
            if (observe() !== e) begin
                miscompares++;
                $display("[TB] FAIL exhaustion k=%0d got %s, expected %s", k, fmt(observe()), fmt(e));
            end
            advance(k + 1, -1, -1, -1);
        end
        @(negedge clk);
        start       = 1'b1;
        release_req = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        release_req = 1'b0;
        e = '0;
        e.fault = 1'b1;
        e.retry = 3'd3;
        vectors++;
        if (observe() !== e) begin
            miscompares++;
            $display("[TB] FAIL fault_sticky got %s, expected %s", fmt(observe()), fmt(e));
        end
    endtask

    task automatic test_partial();
        vec_t e;
        launch(0, 1'b1, 1'b0);
        for (int k = 0; k < FAULT_AT + 3; k++) begin
            e = exp_at(k, 4, -1, -1, -1);
            vectors++;
            if (observe() !== e) begin
                miscompares++;
                $display("[TB] FAIL partial k=%0d got %s, expected %s", k, fmt(observe()), fmt(e));
            end
            advance(k + 1, -1, -1, -1);
        end
    endtask

    task automatic test_hardlock();
        int accs[3]   = '{4, 4, 0};
        int hl_at[3]  = '{5, 20, 6};
        vec_t e;
        for (int run = 0; run < 3; run++) begin
            launch(accs[run], 1'b0, 1'b0);
            for (int k = 0; k < hl_at[run] + 4; k++) begin
                e = exp_at(k, accs[run], hl_at[run], -1, -1);
                vectors++;
                if (observe() !== e) begin
                    miscompares++;
                    $display("[TB] FAIL hardlock run=%0d k=%0d got %s, expected %s",
                             run, k, fmt(observe()), fmt(e));
                end
                advance(k + 1, hl_at[run], -1, -1);
            end
            #2;
            rst_n = 1'b0;
            #1;
            vectors++;
            if (observe() !== vec_t'('0)) begin
                miscompares++;
                $display("[TB] FAIL async_reset run=%0d got %s, expected all zero", run, fmt(observe()));
            end
        end
    endtask

    task automatic test_loss();
        vec_t e;
        for (int run = 0; run < 2; run++) begin
            launch(0, 1'b0, 1'b0);
            for (int k = 0; k < 10; k++) begin
                e = exp_at(k, 0, -1, (run == 1) ? 5 : -1, 5);
                vectors++;
                if (observe() !== e) begin
                    miscompares++;
                    $display("[TB] FAIL loss run=%0d k=%0d got %s, expected %s",
                             run, k, fmt(observe()), fmt(e));
                end
                advance(k + 1, -1, (run == 1) ? 5 : -1, 5);
            end
        end
    endtask

    task automatic test_random();
        vec_t e;
        int acc, kind, ev, hl_e, rel_e, drop_e;
        for (int it = 0; it < 8; it++) begin
            acc    = int'($urandom_range(0, 4));
            kind   = int'($urandom_range(0, 2));
            ev     = int'($urandom_range(1, 95));
            hl_e   = (kind == 1) ? ev : -1;
            rel_e  = (kind == 2) ? ev : -1;
            drop_e = -1;
            if (acc < 4 && $urandom_range(0, 1) == 1)
                drop_e = acc * PERIOD + 3 + int'($urandom_range(0, 5));
            launch(acc, 1'b0, 1'b0);
            for (int k = 0; k < 100; k++) begin
                e = exp_at(k, acc, hl_e, rel_e, drop_e);
                vectors++;
                if (observe() !== e) begin
                    miscompares++;
                    $display("[TB] FAIL random it=%0d acc=%0d hl=%0d rel=%0d drop=%0d k=%0d got %s, expected %s",
                             it, acc, hl_e, rel_e, drop_e, k, fmt(observe()), fmt(e));
                end
                advance(k + 1, hl_e, rel_e, drop_e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_retry();
        test_exhaustion();
        test_partial();
        test_hardlock();
        test_loss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
